n64_vbus_demux: RTL and testbench

Front-end stage of the N64 video path. Samples the multiplexed N64 video bus (sync word plus three 7-bit colour words per pixel, framed by nVDSYNC) on VCLK. Produces the registered sync history vectors and delayed nVDSYNC consumed by the video-info extractor, plus an aligned 21-bit RGB pixel word. A phase-lock monitor validates the 4-cycle bus framing and counts framing errors.

---
 rtl/n64_vbus_demux.sv | 123 ++++++++++++
 tb/tb_n64_vbus_demux.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/n64_vbus_demux.sv
// Demultiplexes the N64 video bus into sync history and 21-bit RGB pixels, and
// tracks 4-cycle framing lock with a saturating framing-error counter.
module n64_vbus_demux #(
    parameter int unsigned LOCK_CNT = 4
) (
    input  logic        VCLK,
    input  logic        RST,
    input  logic        nVDSYNC,
    input  logic [6:0]  D_i,
    input  logic        err_clr,
    output logic        nVDSYNC_o,
    output logic [3:0]  Sync_pre,
    output logic [3:0]  Sync_cur,
    output logic [24:0] vdata_o,
    output logic        vdata_valid,
    output logic        locked,
    output logic [7:0]  err_cnt
);

    typedef enum logic {ST_UNLOCKED, ST_LOCKED} state_t;

    localparam logic [3:0] LOCK_TGT = 4'(LOCK_CNT);

    state_t      state_q, state_d;
    logic [3:0]  good_cnt_q, good_cnt_d;
    logic [2:0]  gap_q, gap_d;
    logic [3:0]  sync_pre_q, sync_cur_q;
    logic        nvdsync_q;
    logic [6:0]  r_tmp_q, g_tmp_q;
    logic [24:0] vdata_q;
    logic        vdata_valid_q;
    logic [7:0]  err_cnt_q, err_cnt_d;

    logic sync_lo, good_sync, frame_err, pix_done;

    always_comb begin
        sync_lo   = ~nVDSYNC;
        good_sync = sync_lo && (gap_q == 3'd3);
        // Timeout fires only on the 6->7 step, so a stuck-high strobe costs one error.
        frame_err = (sync_lo && (gap_q != 3'd3)) || (!sync_lo && (gap_q == 3'd6));
        pix_done  = !sync_lo && (gap_q == 3'd2);
        gap_d     = sync_lo ? 3'd0 : ((gap_q == 3'd7) ? 3'd7 : gap_q + 3'd1);
    end

    always_comb begin
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        case (state_q)
            ST_UNLOCKED: begin
                if (frame_err) begin
                    good_cnt_d = 4'd0;
                end else if (good_sync) begin
                    if (good_cnt_q + 4'd1 == LOCK_TGT) begin
                        state_d    = ST_LOCKED;
                        good_cnt_d = 4'd0;
                    end else begin
                        good_cnt_d = good_cnt_q + 4'd1;
                    end
                end
            end
            ST_LOCKED: begin
                if (frame_err) begin
                    state_d    = ST_UNLOCKED;
                    good_cnt_d = 4'd0;
                end
            end
            default: begin
                state_d    = ST_UNLOCKED;
                good_cnt_d = 4'd0;
            end
        endcase
    end

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = 8'd0;
        end else if (frame_err && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // Syncs reset to all-ones (inactive) so downstream edge detectors see nothing.
    always_ff @(posedge VCLK or posedge RST) begin
        if (RST) begin
            state_q       <= ST_UNLOCKED;
            good_cnt_q    <= 4'd0;
            gap_q         <= 3'd7;
            sync_pre_q    <= 4'hF;
            sync_cur_q    <= 4'hF;
            nvdsync_q     <= 1'b1;
            r_tmp_q       <= 7'd0;
            g_tmp_q       <= 7'd0;
            vdata_q       <= 25'd0;
            vdata_valid_q <= 1'b0;
            err_cnt_q     <= 8'd0;
        end else begin
            state_q       <= state_d;
            good_cnt_q    <= good_cnt_d;
            gap_q         <= gap_d;
            nvdsync_q     <= nVDSYNC;
            err_cnt_q     <= err_cnt_d;
            vdata_valid_q <= pix_done && (state_q == ST_LOCKED);
            if (sync_lo) begin
                sync_cur_q <= D_i[3:0];
                sync_pre_q <= sync_cur_q;
            end else begin
                if (gap_q == 3'd0) r_tmp_q <= D_i;
                if (gap_q == 3'd1) g_tmp_q <= D_i;
                if (pix_done)      vdata_q <= {sync_cur_q, r_tmp_q, g_tmp_q, D_i};
            end
        end
    end

    assign nVDSYNC_o   = nvdsync_q;
    assign Sync_pre    = sync_pre_q;
    assign Sync_cur    = sync_cur_q;
    assign vdata_o     = vdata_q;
    assign vdata_valid = vdata_valid_q;
    assign locked      = (state_q == ST_LOCKED);
    assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_n64_vbus_demux.sv
// Directed and randomized bench for n64_vbus_demux against a cycle-level reference model.
module tb_n64_vbus_demux;

    logic        VCLK = 1'b0;
    logic        RST;
    logic        nVDSYNC;
    logic [6:0]  D_i;
    logic        err_clr;
    logic        nVDSYNC_o;
    logic [3:0]  Sync_pre, Sync_cur;
    logic [24:0] vdata_o;
    logic        vdata_valid, locked;
    logic [7:0]  err_cnt;

    int checks = 0;
    int errors = 0;

    n64_vbus_demux #(.LOCK_CNT(4)) dut (
        .VCLK(VCLK), .RST(RST), .nVDSYNC(nVDSYNC), .D_i(D_i), .err_clr(err_clr),
        .nVDSYNC_o(nVDSYNC_o), .Sync_pre(Sync_pre), .Sync_cur(Sync_cur),
        .vdata_o(vdata_o), .vdata_valid(vdata_valid), .locked(locked), .err_cnt(err_cnt)
    );

    always #5 VCLK = ~VCLK;

    // Reference state: cycles since last sync, consecutive good syncs, error tally.
    int          m_since, m_good, m_err;
    bit          m_locked, m_valid, m_nvo;
    logic [3:0]  m_pre, m_cur;
    logic [6:0]  m_r, m_g;
    logic [24:0] m_vdata;

    function automatic void model_reset();
        m_since = 7; m_good = 0; m_err = 0;
        m_locked = 0; m_valid = 0; m_nvo = 1;
        m_pre = 4'hF; m_cur = 4'hF; m_r = '0; m_g = '0; m_vdata = '0;
    endfunction

    function automatic void model_step(input logic nv, input logic [6:0] d, input logic clr);
        bit err, good, done;
        good = !nv && (m_since == 3);
        err  = (!nv && (m_since != 3)) || (nv && (m_since == 6));
        done = nv && (m_since == 2);
        m_valid = done && m_locked;
        if (done) m_vdata = {m_cur, m_r, m_g, d};
        if (nv && m_since == 0) m_r = d;
        if (nv && m_since == 1) m_g = d;
        if (!nv) begin
            m_pre = m_cur;
            m_cur = d[3:0];
        end
        m_nvo = nv;
        if (err) begin
            m_locked = 0;
            m_good = 0;
        end else if (good && !m_locked) begin
            m_good++;
            if (m_good == 4) begin
                m_locked = 1;
                m_good = 0;
            end
        end
        if (clr) m_err = 0;
        else if (err && m_err < 255) m_err++;
        m_since = !nv ? 0 : ((m_since >= 7) ? 7 : m_since + 1);
    endfunction

    task automatic check_all(input string tag);
        checks++; assert (nVDSYNC_o === m_nvo) else begin errors++; $error("FAIL %s nVDSYNC_o got %b expected %b", tag, nVDSYNC_o, m_nvo); end
        checks++; assert (Sync_pre === m_pre) else begin errors++; $error("FAIL %s Sync_pre got %h expected %h", tag, Sync_pre, m_pre); end
        checks++; assert (Sync_cur === m_cur) else begin errors++; $error("FAIL %s Sync_cur got %h expected %h", tag, Sync_cur, m_cur); end
        checks++; assert (vdata_o === m_vdata) else begin errors++; $error("FAIL %s vdata_o got %h expected %h", tag, vdata_o, m_vdata); end
        checks++; assert (vdata_valid === m_valid) else begin errors++; $error("FAIL %s vdata_valid got %b expected %b", tag, vdata_valid, m_valid); end
        checks++; assert (locked === m_locked) else begin errors++; $error("FAIL %s locked got %b expected %b", tag, locked, m_locked); end
        checks++; assert (err_cnt === 8'(m_err)) else begin errors++; $error("FAIL %s err_cnt got %0d expected %0d", tag, err_cnt, m_err); end
    endtask

    task automatic cyc(input string tag, input logic nv, input logic [6:0] d, input logic clr);
        nVDSYNC = nv; D_i = d; err_clr = clr;
        @(posedge VCLK);
        model_step(nv, d, clr);
        @(negedge VCLK);
        check_all(tag);
    endtask

    task automatic frame(input string tag, input logic [3:0] s, input logic [6:0] r, input logic [6:0] g, input logic [6:0] b);
        cyc(tag, 1'b0, {3'($urandom_range(0, 7)), s}, 1'b0);
        cyc(tag, 1'b1, r, 1'b0);
        cyc(tag, 1'b1, g, 1'b0);
        cyc(tag, 1'b1, b, 1'b0);
    endtask

    task automatic expect_const(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin errors++; $error("FAIL %s got %0h expected %0h", tag, got, exp); end
    endtask

    initial begin
        logic [24:0] pix_exp;
        int kind, n;
        pix_exp = {4'hB, 7'h11, 7'h22, 7'h33};

        // Reset
        RST = 1'b1; nVDSYNC = 1'b1; D_i = '0; err_clr = 1'b0;
        model_reset();
        repeat (2) @(negedge VCLK);
        check_all("reset");
        expect_const("reset_sync_cur", 32'(Sync_cur), 32'hF);
        RST = 1'b0;

        // Six clean frames: lock after the 5th sync, first sync counted bad
        for (int i = 0; i < 6; i++) begin
            cyc("clean_sync", 1'b0, 7'h0B, 1'b0);
            if (i == 3) expect_const("not_locked_4th_sync", 32'(locked), 32'd0);
            if (i == 4) expect_const("locked_5th_sync", 32'(locked), 32'd1);
            cyc("clean_r", 1'b1, 7'h11, 1'b0);
            cyc("clean_g", 1'b1, 7'h22, 1'b0);
            cyc("clean_b", 1'b1, 7'h33, 1'b0);
            if (i >= 4) expect_const("clean_valid", 32'(vdata_valid), 32'd1);
        end
        expect_const("clean_err_cnt", 32'(err_cnt), 32'd1);
        expect_const("clean_vdata", 32'(vdata_o), 32'(pix_exp));

        // Sync history F then 7
        frame("hist", 4'hF, 7'h01, 7'h02, 7'h03);
        cyc("hist_sync7", 1'b0, 7'h07, 1'b0);
        expect_const("hist_pre", 32'(Sync_pre), 32'hF);
        expect_const("hist_cur", 32'(Sync_cur), 32'h7);
        expect_const("hist_nv", 32'(nVDSYNC_o), 32'd0);
        cyc("hist_r", 1'b1, 7'h10, 1'b0);
        cyc("hist_g", 1'b1, 7'h20, 1'b0);
        cyc("hist_b", 1'b1, 7'h30, 1'b0);

        // Early sync at gap==1 while locked
        cyc("early_sync", 1'b0, 7'h0B, 1'b0);
        cyc("early_r", 1'b1, 7'h44, 1'b0);
        cyc("early_bad", 1'b0, 7'h0B, 1'b0);
        expect_const("early_unlock", 32'(locked), 32'd0);
        expect_const("early_err", 32'(err_cnt), 32'd2);
        cyc("early_r2", 1'b1, 7'h45, 1'b0);
        cyc("early_g2", 1'b1, 7'h46, 1'b0);
        cyc("early_b2", 1'b1, 7'h47, 1'b0);
        for (int i = 0; i < 5; i++) frame("relock", 4'hA, 7'h55, 7'h66, 7'h77);
        expect_const("relocked", 32'(locked), 32'd1);

        // Stuck-high strobe while locked: one timeout error only
        for (int i = 0; i < 20; i++) cyc("stuck_high", 1'b1, 7'($urandom), 1'b0);
        expect_const("stuck_err", 32'(err_cnt), 32'd3);
        expect_const("stuck_unlock", 32'(locked), 32'd0);

        // Randomized traffic
        for (int it = 0; it < 120; it++) begin
            kind = $urandom_range(0, 9);
            if (kind <= 6) begin
                frame("rand_frame", 4'($urandom), 7'($urandom), 7'($urandom), 7'($urandom));
            end else if (kind == 7) begin
                n = $urandom_range(0, 2);
                cyc("rand_short", 1'b0, 7'($urandom), 1'b0);
                for (int j = 0; j < n; j++) cyc("rand_short", 1'b1, 7'($urandom), 1'b0);
            end else if (kind == 8) begin
                n = $urandom_range(3, 9);
                cyc("rand_long", 1'b0, 7'($urandom), 1'b0);
                for (int j = 0; j < n; j++) cyc("rand_long", 1'b1, 7'($urandom), 1'b0);
            end else begin
                cyc("rand_clr", 1'($urandom), 7'($urandom), 1'b1);
            end
        end

        // Saturation then clear colliding with an error
        for (int i = 0; i < 300; i++) cyc("sat", 1'b0, 7'($urandom), 1'b0);
        expect_const("sat_255", 32'(err_cnt), 32'd255);
        cyc("clr_vs_err", 1'b0, 7'h0F, 1'b1);
        expect_const("clr_wins", 32'(err_cnt), 32'd0);

        // Reset asserted between G and B words while locked
        for (int i = 0; i < 5; i++) frame("prerst", 4'hB, 7'h11, 7'h22, 7'h33);
        cyc("prerst_sync", 1'b0, 7'h0C, 1'b0);
        cyc("prerst_r", 1'b1, 7'h5A, 1'b0);
        cyc("prerst_g", 1'b1, 7'h3C, 1'b0);
        RST = 1'b1;
        #1;
        model_reset();
        check_all("rst_async");
        nVDSYNC = 1'b1; D_i = 7'h69;
        @(posedge VCLK);
        @(negedge VCLK);
        check_all("rst_held");
        RST = 1'b0;
        cyc("post_rst_b", 1'b1, 7'h69, 1'b0);
        expect_const("post_rst_valid", 32'(vdata_valid), 32'd0);
        frame("post_rst", 4'h3, 7'h0A, 7'h0B, 7'h0C);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
